// File: rtl/opc1_mem_arb.sv
// Two-port arbiter/sequencer for the OPC1 2048x8 synchronous RAM.
// One RAM access per grant: IDLE -> ISSUE -> WAIT -> IDLE, ack pulsed on return.
module opc1_mem_arb #(
  parameter int AW             = 11,
  parameter int DW             = 8,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic [DW-1:0] a_rdata,
  output logic          a_ack,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic [DW-1:0] b_rdata,
  output logic          b_ack,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  logic [1:0] state;
  logic       owner;
  logic       last;
  logic       lat_we;

  logic a_elig;
  logic b_elig;
  logic grant;
  logic win;

  // A port whose ack is high this cycle is done and must not be re-issued.
  assign a_elig = a_req & ~a_ack;
  assign b_elig = b_req & ~b_ack;
  assign grant  = (state == IDLE) & (a_elig | b_elig);

  always_comb begin
    win = PORT_A;
    if (a_elig && b_elig) begin
      if (FIXED_PRIORITY != 0)
        win = PORT_A;
      else
        win = ~last;
    end else if (b_elig) begin
      win = PORT_B;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= PORT_A;
      last      <= PORT_B;
      lat_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            state  <= ISSUE;
            owner  <= win;
            last   <= win;
            if (win == PORT_B) begin
              lat_we    <= b_we;
              mem_addr  <= b_addr;
              mem_wdata <= b_wdata;
            end else begin
              lat_we    <= a_we;
              mem_addr  <= a_addr;
              mem_wdata <= a_wdata;
            end
          end
        end
        ISSUE:   state <= WAIT;
        WAIT:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      a_ack <= (state == WAIT) & (owner == PORT_A);
      b_ack <= (state == WAIT) & (owner == PORT_B);
      if (state == WAIT && !lat_we) begin
        if (owner == PORT_A)
          a_rdata <= mem_rdata;
        else
          b_rdata <= mem_rdata;
      end
    end
  end

  assign mem_we = (state == ISSUE) & lat_we;
  assign mem_re = (state == ISSUE) & ~lat_we;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_opc1_mem_arb.sv
// Directed bench for opc1_mem_arb: round-robin and fixed-priority
// instances share stimulus, each with its own synchronous RAM model.
module tb_opc1_mem_arb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [10:0] a_addr = '0;
  logic [7:0]  a_wdata = '0;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [10:0] b_addr = '0;
  logic [7:0]  b_wdata = '0;

  logic [7:0]  a_rdata0, b_rdata0, mem_wdata0, mem_rdata0;
  logic        a_ack0, b_ack0, mem_we0, mem_re0, busy0;
  logic [10:0] mem_addr0;
  logic [7:0]  a_rdata1, b_rdata1, mem_wdata1, mem_rdata1;
  logic        a_ack1, b_ack1, mem_we1, mem_re1, busy1;
  logic [10:0] mem_addr1;

  logic        pre_we = 1'b0;
  logic [10:0] pre_addr = '0;
  logic [7:0]  pre_data = '0;
  logic [7:0]  ram0 [0:2047];
  logic [7:0]  ram1 [0:2047];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  opc1_mem_arb #(.AW(11), .DW(8), .FIXED_PRIORITY(0)) u0 (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata0), .a_ack(a_ack0),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata0), .b_ack(b_ack0),
    .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_we(mem_we0),
    .mem_re(mem_re0), .mem_rdata(mem_rdata0), .busy(busy0)
  );

  opc1_mem_arb #(.AW(11), .DW(8), .FIXED_PRIORITY(1)) u1 (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata1), .a_ack(a_ack1),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata1), .b_ack(b_ack1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_we(mem_we1),
    .mem_re(mem_re1), .mem_rdata(mem_rdata1), .busy(busy1)
  );

  always @(posedge clk) begin
    if (pre_we) ram0[pre_addr] <= pre_data;
    else if (mem_we0) ram0[mem_addr0] <= mem_wdata0;
    if (mem_re0) mem_rdata0 <= ram0[mem_addr0];
  end

  always @(posedge clk) begin
    if (pre_we) ram1[pre_addr] <= pre_data;
    else if (mem_we1) ram1[mem_addr1] <= mem_wdata1;
    if (mem_re1) mem_rdata1 <= ram1[mem_addr1];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [10:0] ad, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = ad; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic do_reset();
    a_req = 1'b0; b_req = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    tick();
    preload(11'h123, 8'h5A);
    preload(11'h100, 8'h11);
    preload(11'h200, 8'h22);
    preload(11'h010, 8'h00);
    do_reset();

    // reset state
    chk("rst_a_ack", 32'(a_ack0), 32'h0);
    chk("rst_busy", 32'(busy0), 32'h0);
    chk("rst_a_rdata", 32'(a_rdata0), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr0), 32'h0);
    chk("rst_strobes", 32'({mem_we0, mem_re0}), 32'h0);

    // single read by A
    a_req = 1'b1; a_we = 1'b0; a_addr = 11'h123;
    tick();
    chk("rd_c1_re", 32'(mem_re0), 32'h1);
    chk("rd_c1_we", 32'(mem_we0), 32'h0);
    chk("rd_c1_addr", 32'(mem_addr0), 32'h123);
    chk("rd_c1_busy", 32'(busy0), 32'h1);
    tick();
    chk("rd_c2_re", 32'(mem_re0), 32'h0);
    chk("rd_c2_ack", 32'(a_ack0), 32'h0);
    tick();
    chk("rd_c3_ack", 32'(a_ack0), 32'h1);
    chk("rd_c3_rdata", 32'(a_rdata0), 32'h5A);
    chk("rd_c3_back", 32'(b_ack0), 32'h0);
    chk("rd_c3_busy", 32'(busy0), 32'h0);
    a_req = 1'b0;
    tick();
    chk("rd_c4_ack", 32'(a_ack0), 32'h0);

    // B write then read of top address
    b_req = 1'b1; b_we = 1'b1; b_addr = 11'h7FF; b_wdata = 8'hC3;
    tick();
    chk("wr_c1_we", 32'(mem_we0), 32'h1);
    chk("wr_c1_re", 32'(mem_re0), 32'h0);
    chk("wr_c1_addr", 32'(mem_addr0), 32'h7FF);
    chk("wr_c1_wdata", 32'(mem_wdata0), 32'hC3);
    tick();
    chk("wr_c2_we", 32'(mem_we0), 32'h0);
    tick();
    chk("wr_c3_ack", 32'(b_ack0), 32'h1);
    chk("wr_c3_rdata", 32'(b_rdata0), 32'h0);
    b_we = 1'b0;
    tick();
    chk("wr_c4_busy", 32'(busy0), 32'h0);
    chk("wr_c4_ack", 32'(b_ack0), 32'h0);
    tick();
    chk("rb_c1_re", 32'(mem_re0), 32'h1);
    tick();
    tick();
    chk("rb_c3_ack", 32'(b_ack0), 32'h1);
    chk("rb_c3_rdata", 32'(b_rdata0), 32'hC3);
    b_req = 1'b0;
    tick();

    // continuous contention from reset: A,B,A,B every 3 cycles
    do_reset();
    a_req = 1'b1; a_we = 1'b0; a_addr = 11'h100;
    b_req = 1'b1; b_we = 1'b0; b_addr = 11'h200;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk($sformatf("rr_a_ack_%0d", i), 32'(a_ack0), 32'(i == 3 || i == 9));
      chk($sformatf("rr_b_ack_%0d", i), 32'(b_ack0), 32'(i == 6 || i == 12));
      chk($sformatf("fp_a_ack_%0d", i), 32'(a_ack1), 32'(i == 3 || i == 9));
      chk($sformatf("fp_b_ack_%0d", i), 32'(b_ack1), 32'(i == 6 || i == 12));
    end
    chk("rr_a_rdata", 32'(a_rdata0), 32'h11);
    chk("rr_b_rdata", 32'(b_rdata0), 32'h22);
    a_req = 1'b0; b_req = 1'b0;
    tick();

    // after A served last, simultaneous request: RR picks B, fixed picks A
    do_reset();
    a_req = 1'b1; a_addr = 11'h100;
    tick(); tick(); tick();
    chk("pri_pre_ack", 32'(a_ack0), 32'h1);
    a_req = 1'b0;
    tick();
    a_req = 1'b1; b_req = 1'b1;
    tick(); tick(); tick();
    chk("pri_rr_b", 32'(b_ack0), 32'h1);
    chk("pri_rr_a", 32'(a_ack0), 32'h0);
    chk("pri_fp_a", 32'(a_ack1), 32'h1);
    chk("pri_fp_b", 32'(b_ack1), 32'h0);
    tick(); tick(); tick();
    chk("pri_rr_a2", 32'(a_ack0), 32'h1);
    chk("pri_fp_b2", 32'(b_ack1), 32'h1);
    a_req = 1'b0; b_req = 1'b0;
    tick();

    // reset during WAIT of an A read
    do_reset();
    a_req = 1'b1; a_addr = 11'h123;
    tick(); tick();
    chk("rw_wait_busy", 32'(busy0), 32'h1);
    reset = 1'b1; a_req = 1'b0;
    tick();
    reset = 1'b0;
    chk("rw_ack", 32'(a_ack0), 32'h0);
    chk("rw_busy", 32'(busy0), 32'h0);
    chk("rw_rdata", 32'(a_rdata0), 32'h0);
    chk("rw_addr", 32'(mem_addr0), 32'h0);
    chk("rw_strobes", 32'({mem_we0, mem_re0}), 32'h0);
    tick();
    chk("rw_ack_late", 32'(a_ack0), 32'h0);
    a_req = 1'b1;
    tick(); tick(); tick();
    chk("rw_next_ack", 32'(a_ack0), 32'h1);
    chk("rw_next_rdata", 32'(a_rdata0), 32'h5A);
    a_req = 1'b0;
    tick();

    // reset during ISSUE of a B write: RAM commits, no ack
    do_reset();
    b_req = 1'b1; b_we = 1'b1; b_addr = 11'h010; b_wdata = 8'h99;
    tick();
    chk("ri_we", 32'(mem_we0), 32'h1);
    reset = 1'b1; b_req = 1'b0;
    tick();
    reset = 1'b0;
    chk("ri_ram", 32'(ram0[11'h010]), 32'h99);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ri_back_%0d", i), 32'(b_ack0), 32'h0);
      tick();
    end
    b_we = 1'b0;

    // req dropped after grant still completes
    a_req = 1'b1; a_addr = 11'h100;
    tick();
    a_req = 1'b0;
    tick(); tick();
    chk("drop_ack", 32'(a_ack0), 32'h1);
    chk("drop_rdata", 32'(a_rdata0), 32'h11);
    tick();
    chk("drop_ack_off", 32'(a_ack0), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/opc1_mem_arb.md
# opc1_mem_arb

Two-port arbiter and sequencer for the OPC1 2048x8 synchronous program/data RAM. Port A serves the OPC1 CPU and port B serves a second master (program loader or debug/dump engine). Both share one single-ported RAM. The block picks one request at a time, drives a single RAM access cycle, returns read data, and acknowledges the requester with a one-cycle pulse.

## Interface
Parameters:
- AW, 11, address width (2048-byte RAM)
- DW, 8, data width
- FIXED_PRIORITY, 0, 0 = round-robin between A and B; 1 = A always wins a simultaneous request

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- a_req  in  1  port A request; held high until a_ack
- a_we  in  1  port A write (1) / read (0); stable while a_req is high
- a_addr  in  AW  port A address; stable while a_req is high
- a_wdata  in  DW  port A write data; stable while a_req is high
- a_rdata  out  DW  port A read data register
- a_ack  out  1  port A completion pulse
- b_req, b_we, b_addr, b_wdata, b_rdata, b_ack  same as port A, for port B
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_we  out  1  RAM write strobe
- mem_re  out  1  RAM read strobe
- mem_rdata  in  DW  RAM read data, valid in the cycle after mem_re
- busy  out  1  high whenever the state is not IDLE

## Operation
- The FSM has three states: IDLE, ISSUE, WAIT. The sequence is always IDLE -> ISSUE -> WAIT -> IDLE.
- Eligibility: a port is eligible when its req is 1 and its ack is 0 in that cycle. A port is not eligible in the cycle its ack is high, so a held request is never re-issued.
- In IDLE, if a port is eligible:
  - Select the winner, latch its we/addr/wdata and the owner id, and go to ISSUE.
  - If neither port is eligible, stay in IDLE.
- Arbitration:
  - Only one port eligible: that port wins.
  - Both eligible, FIXED_PRIORITY=1: A wins.
  - Both eligible, FIXED_PRIORITY=0: the port not served last wins. The `last` register updates when a grant is made.
- ISSUE:
  - mem_addr and mem_wdata are driven from the latched values.
  - mem_we = latched we and mem_re = !latched we. These are decoded from the registered state.
  - Next state is WAIT.
- WAIT:
  - Both strobes are 0.
  - At the end of WAIT, the owner's rdata is loaded from mem_rdata, on reads only; on writes rdata keeps its old value. The owner's ack is set to 1.
  - Next state is IDLE.
- ack is registered and high for exactly one cycle. rdata holds its value until the next read completes for that port.
- mem_addr and mem_wdata hold their last latched values outside ISSUE. mem_we and mem_re are 0 outside ISSUE.
- At most one strobe is high in any cycle. mem_we and mem_re are never high together.

## Timing
- Reset values:
  - state IDLE
  - a_ack = b_ack = 0, busy = 0
  - a_rdata = b_rdata = 0
  - mem_addr = 0, mem_wdata = 0, mem_we = mem_re = 0
  - `last` = B, so A wins the first contention
- Let the grant be made at edge E0, which ends IDLE cycle c0.
  - c1 = ISSUE, RAM strobe high.
  - c2 = WAIT, mem_rdata valid.
  - c3: ack = 1 and rdata valid; state is IDLE.
- Latency is 3 cycles from the first IDLE cycle with req sampled to ack visible.
- The requester may change its fields or drop req at the edge ending its ack cycle.
- Throughput:
  - Alternating A/B: one access per 3 cycles. The other port is granted in c3.
  - A single port streaming: one access per 4 cycles.
- Reset mid-operation:
  - Reset sampled at any edge forces the reset values at that edge. No ack is produced for the aborted access.
  - A write whose ISSUE cycle ends at the reset edge is still committed by the RAM. It is not acknowledged.
- A req dropped before its ack (protocol violation) does not cancel an access already granted. The ack is still pulsed.

## Test plan
- Single read: RAM[0x123]=0x5A; a_req=1, a_we=0, a_addr=0x123 -> mem_re high for exactly 1 cycle with mem_addr=0x123; a_ack pulses 1 cycle, 3 cycles after the grant edge, with a_rdata=0x5A; b_ack stays 0.
- Write then read: B writes 0x7FF<-0xC3, then reads 0x7FF -> a single mem_we pulse with mem_addr=0x7FF and mem_wdata=0xC3; the second b_ack returns b_rdata=0xC3; b_rdata is unchanged across the write ack.
- Contention round-robin: a_req and b_req are held high continuously, both reads, from reset -> grants alternate A, B, A, B; an ack every 3 cycles; four accesses complete in 12 cycles.
- FIXED_PRIORITY=1 with both ports requesting continuously -> A is granted every time A is eligible; B is granted only in A's ack cycle.
- Reset mid-access: assert reset during WAIT of an A read -> a_ack never pulses; next cycle state is IDLE with all outputs at reset values; the next request completes normally.
- Reset during an ISSUE write to 0x010 with data 0x99 -> RAM[0x010]=0x99 and no b_ack.
